// File: rtl/fan_pkg.sv
// Shared types and constants for the fan PWM controller slice.
package fan_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SPINUP = 2'd1,
    RUN    = 2'd2,
    HOLD   = 2'd3
  } fan_state_t;

  localparam int              DUTY_W    = 8;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;
  localparam int              TMR_W     = 16;

endpackage

// File: rtl/fan_pwm_ctrl_if.sv
// Control/status bundle between the temperature stabilizer and the fan controller.
// Tach input and stall fault exist only when FAN_TACH_EN is defined.
interface fan_pwm_ctrl_if #(
  parameter int PWM_BITS = 8
);
   logic                i_enable;
   logic                i_cooling_on;
   logic [7:0]          i_temp;
   logic [7:0]          i_thes_up;
   logic                o_fan_pwm;
   logic [PWM_BITS-1:0] o_duty;
   logic [1:0]          o_state;
`ifdef FAN_TACH_EN
   logic                i_tach;
   logic                o_fan_fault;
`endif

   modport master (
      output i_enable, i_cooling_on, i_temp, i_thes_up,
`ifdef FAN_TACH_EN
      output i_tach,
      input  o_fan_fault,
`endif
      input  o_fan_pwm, o_duty, o_state
   );

   modport slave (
      input  i_enable, i_cooling_on, i_temp, i_thes_up,
`ifdef FAN_TACH_EN
      input  i_tach,
      output o_fan_fault,
`endif
      output o_fan_pwm, o_duty, o_state
   );
endinterface

// File: rtl/fan_pwm_gen.sv
// Free-running PWM counter with duty updates gated to period boundaries,
// plus force-load (full duty, counter restart) and force-clear (duty 0).
module fan_pwm_gen #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [PWM_BITS-1:0] duty_tgt,
   input  logic                force_load,
   input  logic                force_clear,
   output logic                pwm_out,
   output logic [PWM_BITS-1:0] duty_q
);
   localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

   logic [PWM_BITS-1:0] pwm_cnt;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side below sees the pre-edge value of pwm_cnt and duty_q.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pwm_cnt <= '0;
         duty_q  <= '0;
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= (pwm_cnt < duty_q);
         pwm_cnt <= force_load ? '0 : pwm_cnt + 1'b1;
         // Clear wins over load; otherwise duty only moves on the wrap edge
         if (force_clear)
            duty_q <= '0;
         else if (force_load)
            duty_q <= '1;
         else if (pwm_cnt == CNT_MAX)
            duty_q <= duty_tgt;
      end
   end
endmodule

// File: rtl/fan_pwm_ctrl.sv
// Fan controller: spin-up, proportional regulation, minimum on-time and run-on hold.
// Optional tach stall supervision is built when FAN_TACH_EN is defined.
module fan_pwm_ctrl
   import fan_pkg::*;
#(
   parameter int PWM_BITS     = DUTY_W,
   parameter int SPINUP_CYC   = 64,
   parameter int MIN_ON_CYC   = 256,
   parameter int HOLD_CYC     = 512,
   parameter int DUTY_MIN     = 32,
   parameter int GAIN_SHIFT   = 2,
   parameter int TACH_TIMEOUT = 1024
) (
   input  logic           clk,
   input  logic           rstn,
   fan_pwm_ctrl_if.slave  bus
);
   localparam logic [PWM_BITS-1:0] FULL_DUTY =
      (PWM_BITS == DUTY_W) ? PWM_BITS'(DUTY_FULL) : '1;
   localparam logic [TMR_W-1:0]    SAT_WIDE  = TMR_W'((1 << PWM_BITS) - 1);
   localparam logic [PWM_BITS-1:0] DMIN      = PWM_BITS'(DUTY_MIN);

   fan_state_t          state;
   logic [TMR_W-1:0]    timer;
   logic [7:0]          diff;
   logic [TMR_W-1:0]    prop_wide;
   logic [PWM_BITS-1:0] prop_sat, run_tgt, duty_tgt;
   logic                go_off, go_spinup, hold_expire, stall, blocked;

   // Proportional target: saturate in the wide domain before narrowing
   assign diff      = (bus.i_temp > bus.i_thes_up) ? bus.i_temp - bus.i_thes_up : 8'd0;
   assign prop_wide = TMR_W'(diff) << GAIN_SHIFT;
   assign prop_sat  = (prop_wide > SAT_WIDE) ? PWM_BITS'(SAT_WIDE) : PWM_BITS'(prop_wide);
   assign run_tgt   = (prop_sat < DMIN) ? DMIN : prop_sat;

   always_comb begin
      duty_tgt = '0;
      unique case (state)
         SPINUP:  duty_tgt = FULL_DUTY;
         RUN:     duty_tgt = run_tgt;
         HOLD:    duty_tgt = DMIN;
         default: duty_tgt = '0;
      endcase
   end

`ifdef FAN_TACH_EN
   logic             tach_s1, tach_s2, tach_s3, fault_q;
   logic [TMR_W-1:0] stall_cnt;
   logic             tach_rise;

   assign tach_rise = tach_s2 & ~tach_s3;
   assign stall     = (state == RUN || state == HOLD) &&
                      (stall_cnt == TMR_W'(TACH_TIMEOUT - 1));
   assign blocked   = fault_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         {tach_s1, tach_s2, tach_s3} <= 3'b000;
         stall_cnt <= '0;
         fault_q   <= 1'b0;
      end else begin
         {tach_s1, tach_s2, tach_s3} <= {bus.i_tach, tach_s1, tach_s2};
         if ((state == RUN || state == HOLD) && !stall && !tach_rise)
            stall_cnt <= stall_cnt + 1'b1;
         else
            stall_cnt <= '0;
         if (!bus.i_enable)
            fault_q <= 1'b0;
         else if (stall)
            fault_q <= 1'b1;
      end
   end

   assign bus.o_fan_fault = fault_q;
`else
   assign stall   = 1'b0;
   assign blocked = 1'b0;
`endif

   // Enable drop and stall beat every other transition; clearing duty on the
   // same edge pulls the PWM low within two cycles.
   assign hold_expire = (state == HOLD) && !bus.i_cooling_on && (timer == '0);
   assign go_off      = !bus.i_enable || stall || hold_expire;
   assign go_spinup   = (state == OFF) && bus.i_enable && bus.i_cooling_on && !blocked;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= OFF;
         timer <= '0;
      end else if (go_off) begin
         state <= OFF;
         timer <= '0;
      end else begin
         unique case (state)
            OFF: if (go_spinup) begin
               state <= SPINUP;
               timer <= TMR_W'(SPINUP_CYC - 1);
            end
            SPINUP: if (timer == '0) begin
               state <= RUN;
               timer <= TMR_W'(MIN_ON_CYC - 1);
            end else begin
               timer <= timer - 1'b1;
            end
            RUN: if (!bus.i_cooling_on && timer == '0) begin
               state <= HOLD;
               timer <= TMR_W'(HOLD_CYC - 1);
            end else if (timer != '0) begin
               timer <= timer - 1'b1;
            end
            HOLD: if (bus.i_cooling_on) begin
               state <= RUN;
               timer <= TMR_W'(MIN_ON_CYC - 1);
            end else begin
               timer <= timer - 1'b1;
            end
            default: state <= OFF;
         endcase
      end
   end

   fan_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
      .clk         (clk),
      .rstn        (rstn),
      .duty_tgt    (duty_tgt),
      .force_load  (go_spinup && !go_off),
      .force_clear (go_off),
      .pwm_out     (bus.o_fan_pwm),
      .duty_q      (bus.o_duty)
   );

   assign bus.o_state = state;
endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// Directed bench for fan_pwm_ctrl: duty table plus hand-timed FSM sequences.
module tb_fan_pwm_ctrl;
   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   errors = 0;

   fan_pwm_ctrl_if #(.PWM_BITS(8)) bus ();

   fan_pwm_ctrl dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] temp;
      logic [7:0] thes;
      logic [7:0] exp_duty;
   } vec_t;

   vec_t vecs[10];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic count_high(output int n);
      n = 0;
      for (int i = 0; i < 256; i++) begin
         tick(1);
         n += int'(bus.o_fan_pwm);
      end
   endtask

`ifdef FAN_TACH_EN
   bit tach_auto = 1'b1;
   initial begin
      bus.i_tach = 1'b0;
      forever begin
         repeat (50) @(posedge clk);
         #2;
         bus.i_tach = tach_auto ? ~bus.i_tach : 1'b0;
      end
   end
`endif

   initial begin
      int hi;
      vecs[0] = '{8'd40,  8'd30, 8'd40};
      vecs[1] = '{8'd200, 8'd30, 8'd255};
      vecs[2] = '{8'd31,  8'd30, 8'd32};
      vecs[3] = '{8'd25,  8'd30, 8'd32};
      vecs[4] = '{8'd30,  8'd30, 8'd32};
      vecs[5] = '{8'd37,  8'd30, 8'd32};
      vecs[6] = '{8'd60,  8'd30, 8'd120};
      vecs[7] = '{8'd93,  8'd30, 8'd252};
      vecs[8] = '{8'd94,  8'd30, 8'd255};
      vecs[9] = '{8'd255, 8'd0,  8'd255};

      bus.i_enable = 1'b0; bus.i_cooling_on = 1'b0;
      bus.i_temp = 8'd0;   bus.i_thes_up = 8'd0;
      rstn = 1'b0;
      tick(5);
      check("reset_pwm",   32'(bus.o_fan_pwm), 32'd0);
      check("reset_duty",  32'(bus.o_duty),    32'd0);
      check("reset_state", 32'(bus.o_state),   32'd0);
      rstn = 1'b1;
      tick(1);
      check("idle_state", 32'(bus.o_state), 32'd0);

      // Spin-up then proportional regulation
      bus.i_enable = 1'b1; bus.i_cooling_on = 1'b1;
      bus.i_temp = 8'd40;  bus.i_thes_up = 8'd30;
      tick(1);
      check("spinup_entry_state", 32'(bus.o_state), 32'd1);
      check("spinup_entry_duty",  32'(bus.o_duty),  32'd255);
      tick(63);
      check("spinup_last_cycle", 32'(bus.o_state), 32'd1);
      tick(1);
      check("run_entry", 32'(bus.o_state), 32'd2);
      tick(191);
      check("duty_before_wrap", 32'(bus.o_duty), 32'd255);
      tick(1);
      check("duty_at_wrap", 32'(bus.o_duty), 32'd40);
      count_high(hi);
      check("pwm_high_40", 32'(hi), 32'd40);

      for (int v = 0; v < 10; v++) begin
         bus.i_temp = vecs[v].temp; bus.i_thes_up = vecs[v].thes;
         tick(512);
         check($sformatf("vec%0d_duty", v), 32'(bus.o_duty), 32'(vecs[v].exp_duty));
         count_high(hi);
         check($sformatf("vec%0d_high", v), 32'(hi), 32'(vecs[v].exp_duty));
      end

      // Enable drop from RUN, then abort in SPINUP
      bus.i_temp = 8'd40; bus.i_thes_up = 8'd30;
      bus.i_enable = 1'b0;
      tick(1);
      check("run_abort_state", 32'(bus.o_state), 32'd0);
      check("run_abort_duty",  32'(bus.o_duty),  32'd0);
      tick(1);
      check("run_abort_pwm", 32'(bus.o_fan_pwm), 32'd0);
      bus.i_enable = 1'b1;
      tick(1);
      check("respin_state", 32'(bus.o_state), 32'd1);
      tick(9);
      bus.i_enable = 1'b0;
      tick(1);
      check("spin_abort_state", 32'(bus.o_state), 32'd0);
      check("spin_abort_duty",  32'(bus.o_duty),  32'd0);
      tick(1);
      check("spin_abort_pwm", 32'(bus.o_fan_pwm), 32'd0);
      hi = 0;
      for (int i = 0; i < 20; i++) begin tick(1); hi += int'(bus.o_fan_pwm); end
      check("off_pwm_quiet", 32'(hi), 32'd0);

      // Minimum on-time, hold at floor duty, then switch-off
      bus.i_enable = 1'b1; bus.i_cooling_on = 1'b1;
      tick(1);
      check("mo_spinup", 32'(bus.o_state), 32'd1);
      tick(64);
      check("mo_run", 32'(bus.o_state), 32'd2);
      tick(100);
      bus.i_cooling_on = 1'b0;
      tick(155);
      check("mo_run_last", 32'(bus.o_state), 32'd2);
      tick(1);
      check("mo_hold_entry", 32'(bus.o_state), 32'd3);
      tick(279);
      check("hold_state_mid", 32'(bus.o_state), 32'd3);
      check("hold_duty",      32'(bus.o_duty),  32'd32);
      tick(232);
      check("hold_last", 32'(bus.o_state), 32'd3);
      tick(1);
      check("hold_expire_state", 32'(bus.o_state), 32'd0);
      check("hold_expire_duty",  32'(bus.o_duty),  32'd0);

      // Reassert during HOLD returns to RUN without spin-up
      bus.i_cooling_on = 1'b1;
      tick(1);
      check("rr_spinup", 32'(bus.o_state), 32'd1);
      tick(64);
      bus.i_cooling_on = 1'b0;
      tick(256);
      check("rr_hold", 32'(bus.o_state), 32'd3);
      tick(299);
      bus.i_cooling_on = 1'b1;
      tick(1);
      check("rr_reassert_run", 32'(bus.o_state), 32'd2);
      bus.i_cooling_on = 1'b0;
      tick(255);
      check("rr_minon_last", 32'(bus.o_state), 32'd2);
      tick(1);
      check("rr_hold_again", 32'(bus.o_state), 32'd3);
      tick(511);
      check("rr_hold_timer0", 32'(bus.o_state), 32'd3);
      bus.i_cooling_on = 1'b1;
      tick(1);
      check("reassert_beats_expiry", 32'(bus.o_state), 32'd2);

      // Enable drop on the same edge as spin-up expiry
      bus.i_enable = 1'b0;
      tick(1);
      bus.i_enable = 1'b1;
      tick(1);
      tick(63);
      check("sp_last_before_drop", 32'(bus.o_state), 32'd1);
      bus.i_enable = 1'b0;
      tick(1);
      check("enable_beats_expiry", 32'(bus.o_state), 32'd0);

`ifdef FAN_TACH_EN
      tach_auto = 1'b0;
      tick(100);
      bus.i_enable = 1'b1; bus.i_cooling_on = 1'b1;
      tick(65);
      check("tach_run", 32'(bus.o_state), 32'd2);
      tick(1023);
      check("tach_pre_state", 32'(bus.o_state),     32'd2);
      check("tach_pre_fault", 32'(bus.o_fan_fault), 32'd0);
      tick(1);
      check("tach_fault",       32'(bus.o_fan_fault), 32'd1);
      check("tach_fault_state", 32'(bus.o_state),     32'd0);
      check("tach_fault_duty",  32'(bus.o_duty),      32'd0);
      tick(20);
      check("tach_blocked",     32'(bus.o_state),     32'd0);
      check("tach_sticky",      32'(bus.o_fan_fault), 32'd1);
      bus.i_enable = 1'b0;
      tick(1);
      check("tach_fault_clear", 32'(bus.o_fan_fault), 32'd0);
      bus.i_enable = 1'b1;
      tick(1);
      check("tach_restart", 32'(bus.o_state), 32'd1);
`endif

      // Synchronous reset mid-operation
      bus.i_enable = 1'b1; bus.i_cooling_on = 1'b1;
      tick(80);
      rstn = 1'b0;
      tick(1);
      check("midrst_state", 32'(bus.o_state),   32'd0);
      check("midrst_duty",  32'(bus.o_duty),    32'd0);
      check("midrst_pwm",   32'(bus.o_fan_pwm), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
